// File: rtl/speed_feedback_pio_if.sv
// -----------------------------------------------------------------------------
// speed_feedback_pio_if
// Avalon-MM slave bus bundle for the speed feedback input port.
//
// Signals:
//   address     [1:0]   register select
//   chipselect          slave select
//   write_n             active-low write strobe
//   writedata   [31:0]  write data
//   readdata    [31:0]  read data, zero-extended, combinational from address
//
// Modports:
//   master  - the interconnect / CPU side driving the bus
//   slave   - the PIO register block
// -----------------------------------------------------------------------------
interface speed_feedback_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/speed_feedback_pio.sv
// -----------------------------------------------------------------------------
// speed_feedback_pio
// Receive-side PIO for the measured motor speed percentage. The asynchronous
// input is brought into the clk domain with a 2-flop synchronizer, optionally
// debounced by a multi-bit stability filter, and every change of the accepted
// value is latched per bit in EDGECAP, which can raise a maskable interrupt.
//
// Build option:
//   SPEED_FEEDBACK_FILTER_EN  defined   -> stability filter present, a value
//                                          must hold STABLE_CYCLES cycles
//                                          before it is accepted
//                             undefined -> accepted value is the synchronizer
//                                          output, STABLE_CYCLES ignored
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (address, chipselect, write_n, writedata,
//             readdata)
//   in_port   measured speed percentage, asynchronous to clk
//   irq       active-high level interrupt, |(EDGECAP & IRQMASK)
//
// Register map (word addresses):
//   0 DATA     accepted value, read-only
//   1 reserved reads 0
//   2 IRQMASK  read/write
//   3 EDGECAP  read, write-1-to-clear per bit (a new edge beats the clear)
// -----------------------------------------------------------------------------
module speed_feedback_pio #(
    parameter int DATA_WIDTH    = 7,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    speed_feedback_pio_if.slave   bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] sync1_q;
    logic [DATA_WIDTH-1:0] sync2_q;
    logic [DATA_WIDTH-1:0] filtered;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] irqMask_q;
    logic [DATA_WIDTH-1:0] irqMask_d;
    logic [DATA_WIDTH-1:0] edgeCap_q;
    logic [DATA_WIDTH-1:0] edgeCap_d;
    logic [DATA_WIDTH-1:0] edgeBits;
    logic [DATA_WIDTH-1:0] clearBits;
    logic                  writeEn;
    logic                  unused_writedata;

    assign unused_writedata = ^bus.writedata[31:DATA_WIDTH];

    // Two-flop synchronizer; in_port has no timing relationship to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef SPEED_FEEDBACK_FILTER_EN
    localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

    logic [DATA_WIDTH-1:0] candidate_q;
    logic [DATA_WIDTH-1:0] candidate_d;
    logic [7:0]            count_q;
    logic [7:0]            count_d;
    logic [DATA_WIDTH-1:0] filtered_q;
    logic [DATA_WIDTH-1:0] filtered_d;

    // Stability filter: any difference restarts the run, and the count parks
    // at its last value so a long steady input keeps re-accepting the same
    // candidate instead of wrapping around.
    always_comb begin
        candidate_d = candidate_q;
        count_d     = count_q;
        filtered_d  = filtered_q;
        if (sync2_q != candidate_q) begin
            candidate_d = sync2_q;
            count_d     = '0;
        end else if (count_q == LAST_COUNT) begin
            filtered_d = candidate_q;
        end else begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            candidate_q <= '0;
            count_q     <= '0;
            filtered_q  <= '0;
        end else begin
            candidate_q <= candidate_d;
            count_q     <= count_d;
            filtered_q  <= filtered_d;
        end
    end

    assign filtered = filtered_q;
`else
    localparam int unused_stable_cycles = STABLE_CYCLES;

    // Without the filter the second synchronizer stage is the accepted value.
    assign filtered = sync2_q;
`endif

    // A bit that differs from last cycle's accepted value is an edge; since
    // prev starts at 0, the first acceptance after reset is seen as an edge.
    assign edgeBits  = filtered ^ prev_q;
    assign writeEn   = bus.chipselect && !bus.write_n;
    assign clearBits = (writeEn && bus.address == 2'd3) ? bus.writedata[DATA_WIDTH-1:0] : '0;

    // Register writes and edge capture; OR-ing edges in after the clear means
    // a simultaneous set and clear leaves the bit set.
    always_comb begin
        irqMask_d = irqMask_q;
        if (writeEn && bus.address == 2'd2) begin
            irqMask_d = bus.writedata[DATA_WIDTH-1:0];
        end
        edgeCap_d = (edgeCap_q & ~clearBits) | edgeBits;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            irqMask_q <= '0;
            edgeCap_q <= '0;
        end else begin
            prev_q    <= filtered;
            irqMask_q <= irqMask_d;
            edgeCap_q <= edgeCap_d;
        end
    end

    // Zero-latency read mux.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = {{(32-DATA_WIDTH){1'b0}}, filtered};
            2'd2:    bus.readdata = {{(32-DATA_WIDTH){1'b0}}, irqMask_q};
            2'd3:    bus.readdata = {{(32-DATA_WIDTH){1'b0}}, edgeCap_q};
            default: bus.readdata = '0;
        endcase
    end

    assign irq = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_speed_feedback_pio.sv
// -----------------------------------------------------------------------------
// tb_speed_feedback_pio
// Self-checking bench for speed_feedback_pio. Expected acceptance latency
// follows the SPEED_FEEDBACK_FILTER_EN build option.
// -----------------------------------------------------------------------------
module tb_speed_feedback_pio;

    localparam int DATA_WIDTH    = 7;
    localparam int STABLE_CYCLES = 4;
`ifdef SPEED_FEEDBACK_FILTER_EN
    localparam int LAT = 3 + STABLE_CYCLES;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [6:0] inVal;
        logic [6:0] expOld;
        logic [6:0] expData;
        logic [6:0] expCap;
    } vec_t;

    logic                  clk;
    logic                  reset_n;
    logic [DATA_WIDTH-1:0] in_port;
    logic                  irq;
    int                    compared;
    int                    mismatched;
    logic [31:0]           rd;
    vec_t                  vecs [5];

    speed_feedback_pio_if bus ();

    speed_feedback_pio #(
        .DATA_WIDTH    (DATA_WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] value);
        in_port = value;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.readdata;
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        reset_n        = 1'b0;
        applyStimulus(7'h55);

        vecs[0] = '{7'h64, 7'h55, 7'h64, 7'h31};
        vecs[1] = '{7'h00, 7'h64, 7'h00, 7'h64};
        vecs[2] = '{7'h7F, 7'h00, 7'h7F, 7'h7F};
        vecs[3] = '{7'h01, 7'h7F, 7'h01, 7'h7E};
        vecs[4] = '{7'h09, 7'h01, 7'h09, 7'h08};

        // Held in reset with a live input: everything reads zero.
        repeat (3) tick();
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), rd);
            checkOutput($sformatf("reset_read_addr%0d", a), rd, 32'h0);
        end
        checkOutput("reset_irq", {31'h0, irq}, 32'h0);

        // Release reset; first accepted value is an edge on every set bit.
        reset_n = 1'b1;
        repeat (LAT - 1) tick();
        readReg(2'd0, rd);
        checkOutput("reset_data_early", rd, 32'h0);
        tick();
        readReg(2'd0, rd);
        checkOutput("reset_data_accept", rd, 32'h55);
        tick();
        readReg(2'd3, rd);
        checkOutput("reset_edgecap", rd, 32'h55);

        // Table of input steps: exact latency of DATA and the captured edges.
        for (int i = 0; i < 5; i++) begin
            writeReg(2'd3, 32'h7F);
            applyStimulus(vecs[i].inVal);
            repeat (LAT - 1) tick();
            readReg(2'd0, rd);
            checkOutput($sformatf("vec%0d_data_old", i), rd, {25'h0, vecs[i].expOld});
            tick();
            readReg(2'd0, rd);
            checkOutput($sformatf("vec%0d_data_new", i), rd, {25'h0, vecs[i].expData});
            readReg(2'd3, rd);
            checkOutput($sformatf("vec%0d_cap_before", i), rd, 32'h0);
            tick();
            readReg(2'd3, rd);
            checkOutput($sformatf("vec%0d_cap", i), rd, {25'h0, vecs[i].expCap});
        end

        // Unmasked edge raises irq together with EDGECAP; W1C drops it.
        writeReg(2'd2, 32'h01);
        writeReg(2'd3, 32'h7F);
        readReg(2'd2, rd);
        checkOutput("irqmask_readback", rd, 32'h01);
        applyStimulus(7'h08);
        repeat (LAT) tick();
        checkOutput("irq_before_cap", {31'h0, irq}, 32'h0);
        tick();
        readReg(2'd3, rd);
        checkOutput("irq_cap", rd, 32'h01);
        checkOutput("irq_raised", {31'h0, irq}, 32'h1);
        writeReg(2'd3, 32'h01);
        readReg(2'd3, rd);
        checkOutput("irq_cap_cleared", rd, 32'h0);
        checkOutput("irq_cleared", {31'h0, irq}, 32'h0);

        // Masked edge is captured silently, unmasking it raises irq.
        writeReg(2'd2, 32'h00);
        applyStimulus(7'h00);
        repeat (LAT + 1) tick();
        readReg(2'd3, rd);
        checkOutput("masked_cap", rd, 32'h08);
        checkOutput("masked_irq", {31'h0, irq}, 32'h0);
        writeReg(2'd2, 32'h08);
        checkOutput("unmasked_irq", {31'h0, irq}, 32'h1);
        writeReg(2'd3, 32'h00);
        readReg(2'd3, rd);
        checkOutput("w0_keeps_cap", rd, 32'h08);

        // Writes to read-only/reserved addresses and unselected writes.
        writeReg(2'd0, 32'h7F);
        writeReg(2'd1, 32'h7F);
        readReg(2'd0, rd);
        checkOutput("data_write_ignored", rd, 32'h00);
        readReg(2'd1, rd);
        checkOutput("reserved_reads_zero", rd, 32'h0);
        bus.address    = 2'd2;
        bus.writedata  = 32'h7F;
        bus.write_n    = 1'b0;
        tick();
        bus.write_n    = 1'b1;
        readReg(2'd2, rd);
        checkOutput("unselected_write_ignored", rd, 32'h08);

        // Clear of bit 2 lands on the same edge that sets it: set wins.
        writeReg(2'd3, 32'h7F);
        applyStimulus(7'h04);
        repeat (LAT) tick();
        writeReg(2'd3, 32'h04);
        readReg(2'd3, rd);
        checkOutput("collision_set_wins", rd, 32'h04);
        writeReg(2'd3, 32'h04);
        readReg(2'd3, rd);
        checkOutput("collision_later_clear", rd, 32'h0);

`ifdef SPEED_FEEDBACK_FILTER_EN
        // Short glitch is rejected, a held value is accepted.
        applyStimulus(7'h20);
        repeat (LAT + 2) tick();
        writeReg(2'd3, 32'h7F);
        applyStimulus(7'h21);
        repeat (2) tick();
        applyStimulus(7'h20);
        repeat (10) tick();
        readReg(2'd0, rd);
        checkOutput("glitch_data", rd, 32'h20);
        readReg(2'd3, rd);
        checkOutput("glitch_cap", rd, 32'h0);
        applyStimulus(7'h21);
        repeat (10) tick();
        readReg(2'd0, rd);
        checkOutput("hold_data", rd, 32'h21);
        readReg(2'd3, rd);
        checkOutput("hold_cap", rd, 32'h01);
        writeReg(2'd3, 32'h7F);
`endif

        // Asynchronous reset in the middle of a pending interrupt.
        writeReg(2'd2, 32'h7F);
        applyStimulus(7'h44);
        repeat (LAT + 1) tick();
        checkOutput("pre_reset_irq", {31'h0, irq}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_irq", {31'h0, irq}, 32'h0);
        readReg(2'd0, rd);
        checkOutput("async_reset_data", rd, 32'h0);
        readReg(2'd2, rd);
        checkOutput("async_reset_mask", rd, 32'h0);
        readReg(2'd3, rd);
        checkOutput("async_reset_cap", rd, 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
